// File: rtl/cpu_intr_ctrl.sv
// cpu_intr_ctrl
// -------------
// Interrupt controller sitting between N_SRC external event sources and the
// CPU core. Sources are sampled every cycle into pending bits; the lowest
// pending-and-enabled index wins arbitration. Its index and vector-table
// entry are latched, and a request/acknowledge/return handshake runs with the
// core. Only one handler can be in service at a time, so there is no nesting.
//
// Build option:
//   CPU_INTR_EDGE_EN  defined   -> edge-triggered pending bits
//                                  (a pending bit sets on a rising source and
//                                  clears when its request is acknowledged)
//                     undefined -> level-sensitive (pending mirrors the
//                                  sampled sources)
//
// Ports:
//   clk          single clock, all state on the rising edge
//   reset        synchronous, active-high
//   src_i        raw interrupt sources
//   gie_i        global interrupt enable from the core
//   ien_we_i     write strobe for the per-source enable register
//   ien_wdata_i  new enable value
//   vec_we_i     write strobe for one vector-table entry
//   vec_idx_i    vector-table entry index (out-of-range writes are dropped)
//   vec_wdata_i  vector-table entry value
//   ack_i        core accepts the current request
//   ret_i        core returns from the handler
//   irq_o        interrupt request to the core (registered)
//   vec_o        latched vector of the current request/handler (registered)
//   id_o         latched source index (registered)
//   busy_o       handler in service (registered)
//   pending_o    pending bits
//   ien_o        enable register readback
module cpu_intr_ctrl #(
  parameter int          N_SRC      = 4,
  parameter int          VEC_W      = 32,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
  localparam int         ID_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_i,
  input  logic             gie_i,
  input  logic             ien_we_i,
  input  logic [N_SRC-1:0] ien_wdata_i,
  input  logic             vec_we_i,
  input  logic [ID_W-1:0]  vec_idx_i,
  input  logic [VEC_W-1:0] vec_wdata_i,
  input  logic             ack_i,
  input  logic             ret_i,
  output logic             irq_o,
  output logic [VEC_W-1:0] vec_o,
  output logic [ID_W-1:0]  id_o,
  output logic             busy_o,
  output logic [N_SRC-1:0] pending_o,
  output logic [N_SRC-1:0] ien_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t           state_r;
  logic [N_SRC-1:0] src_q_r;
  logic [N_SRC-1:0] ien_r;
  logic [VEC_W-1:0] vec_table_r [N_SRC];

  logic [N_SRC-1:0] pending_s;
  logic [N_SRC-1:0] cand_s;
  logic             any_cand_s;
  logic [ID_W-1:0]  sel_idx_s;

  // Lowest set index of a request vector (index 0 has the highest priority).
  function automatic logic [ID_W-1:0] lowest_set(input logic [N_SRC-1:0] v);
    logic [ID_W-1:0] r;
    r = {ID_W{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = ID_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Source sampling register.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q_r <= {N_SRC{1'b0}};
    end else begin
      src_q_r <= src_i;
    end
  end

`ifdef CPU_INTR_EDGE_EN
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] ack_clr_s;

  // One-hot clear of the pending bit whose request is being acknowledged.
  always_comb begin
    ack_clr_s = {N_SRC{1'b0}};
    if ((state_r == ST_REQ) && ack_i) begin
      for (int i = 0; i < N_SRC; i++) begin
        ack_clr_s[i] = (int'(id_o) == i);
      end
    end else begin
      ack_clr_s = {N_SRC{1'b0}};
    end
  end

  // Edge-triggered pending bits; a new rising edge beats the ack clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= {N_SRC{1'b0}};
    end else begin
      pending_r <= (pending_r & ~ack_clr_s) | (src_i & ~src_q_r);
    end
  end

  assign pending_s = pending_r;
`else
  // Level-sensitive: the sampled sources are the pending bits.
  assign pending_s = src_q_r;
`endif

  // Per-source enable register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ien_r <= {N_SRC{1'b0}};
    end else if (ien_we_i) begin
      ien_r <= ien_wdata_i;
    end else begin
      ien_r <= ien_r;
    end
  end

  // Vector table: reset to an arithmetic progression, single-entry writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SRC; i++) begin
        vec_table_r[i] <= VEC_W'(VEC_BASE + (32'(i) * VEC_STRIDE));
      end
    end else if (vec_we_i && (int'(vec_idx_i) < N_SRC)) begin
      vec_table_r[vec_idx_i] <= vec_wdata_i;
    end else begin
      vec_table_r <= vec_table_r;
    end
  end

  // Arbitration among pending and enabled sources.
  always_comb begin
    cand_s     = pending_s & ien_r;
    any_cand_s = |cand_s;
    sel_idx_s  = lowest_set(cand_s);
  end

  // Request/acknowledge/return handshake with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      irq_o   <= 1'b0;
      busy_o  <= 1'b0;
      id_o    <= {ID_W{1'b0}};
      vec_o   <= {VEC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gie_i && any_cand_s) begin
            state_r <= ST_REQ;
            irq_o   <= 1'b1;
            id_o    <= sel_idx_s;
            vec_o   <= vec_table_r[sel_idx_s];
          end
        end
        ST_REQ: begin
          // ack takes precedence over a simultaneous gie drop.
          if (ack_i) begin
            state_r <= ST_ACTIVE;
            irq_o   <= 1'b0;
            busy_o  <= 1'b1;
          end else if (!gie_i) begin
            state_r <= ST_IDLE;
            irq_o   <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (ret_i) begin
            state_r <= ST_IDLE;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          irq_o   <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  assign pending_o = pending_s;
  assign ien_o     = ien_r;

endmodule

// File: tb/tb_cpu_intr_ctrl.sv
module tb_cpu_intr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  src;
  logic        gie;
  logic        ien_we;
  logic [3:0]  ien_wdata;
  logic        vec_we;
  logic [1:0]  vec_idx;
  logic [31:0] vec_wdata;
  logic        ack;
  logic        ret;
  logic        irq;
  logic [31:0] vec;
  logic [1:0]  id;
  logic        busy;
  logic [3:0]  pending;
  logic [3:0]  ien;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: behavioural view of the controller.
  logic        m_irq      = 1'b0;
  logic        m_busy     = 1'b0;
  logic [1:0]  m_id       = 2'd0;
  logic [31:0] m_vec      = 32'd0;
  logic [3:0]  m_pending  = 4'd0;
  logic [3:0]  m_src_prev = 4'd0;
  logic [3:0]  m_ien      = 4'd0;
  logic [31:0] m_vec_tab [4];

  cpu_intr_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .src_i       (src),
    .gie_i       (gie),
    .ien_we_i    (ien_we),
    .ien_wdata_i (ien_wdata),
    .vec_we_i    (vec_we),
    .vec_idx_i   (vec_idx),
    .vec_wdata_i (vec_wdata),
    .ack_i       (ack),
    .ret_i       (ret),
    .irq_o       (irq),
    .vec_o       (vec),
    .id_o        (id),
    .busy_o      (busy),
    .pending_o   (pending),
    .ien_o       (ien)
  );

  task automatic model_step();
    logic [3:0] cand;
    logic       found;
`ifdef CPU_INTR_EDGE_EN
    logic       acked;
    logic [1:0] old_id;
    acked  = 1'b0;
    old_id = m_id;
`endif
    cand  = m_pending & m_ien;
    found = 1'b0;
    if (reset) begin
      m_irq = 1'b0; m_busy = 1'b0; m_id = 2'd0; m_vec = 32'd0;
      m_pending = 4'd0; m_src_prev = 4'd0; m_ien = 4'd0;
      for (int i = 0; i < 4; i++) m_vec_tab[i] = 32'h100 + 32'(i) * 32'h10;
    end else begin
      if (!m_irq && !m_busy) begin
        if (gie && cand != 4'd0) begin
          for (int i = 0; i < 4; i++) begin
            if (cand[i] && !found) begin
              found = 1'b1; m_id = 2'(i); m_vec = m_vec_tab[i];
            end
          end
          m_irq = 1'b1;
        end
      end else if (m_irq) begin
        if (ack) begin
          m_irq = 1'b0; m_busy = 1'b1;
`ifdef CPU_INTR_EDGE_EN
          acked = 1'b1;
`endif
        end else if (!gie) begin
          m_irq = 1'b0;
        end
      end else if (ret) begin
        m_busy = 1'b0;
      end
`ifdef CPU_INTR_EDGE_EN
      if (acked) m_pending[old_id] = 1'b0;
      m_pending = m_pending | (src & ~m_src_prev);
`else
      m_pending = src;
`endif
      m_src_prev = src;
      if (ien_we) m_ien = ien_wdata;
      if (vec_we) m_vec_tab[vec_idx] = vec_wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; src = 4'b0000; gie = 1'b0; ien_we = 1'b0; ien_wdata = 4'b0000;
    vec_we = 1'b0; vec_idx = 2'd0; vec_wdata = 32'd0; ack = 1'b0; ret = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %h want 0", irq); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
    n_run++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pending); end
    n_run++; if (ien !== 4'b0000) begin n_fail++; $display("FAIL reset_ien: got %h want 0", ien); end
    n_run++; if (id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %h want 0", id); end
    n_run++; if (vec !== 32'd0) begin n_fail++; $display("FAIL reset_vec: got %h want 0", vec); end
  endtask

  task automatic test_single();
    ien_we = 1'b1; ien_wdata = 4'b1111; tick(); ien_we = 1'b0;
    n_run++; if (ien !== 4'b1111) begin n_fail++; $display("FAIL single_ien: got %h want f", ien); end
    gie = 1'b1; src = 4'b0100; tick(); src = 4'b0000;
    n_run++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL single_pending: got %h want 4", pending); end
    n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_early: got %h want 0", irq); end
    tick();
    n_run++; if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq: got %h want 1", irq); end
    n_run++; if (id !== 2'd2) begin n_fail++; $display("FAIL single_id: got %h want 2", id); end
    n_run++; if (vec !== 32'h120) begin n_fail++; $display("FAIL single_vec: got %h want 120", vec); end
    ack = 1'b1; tick(); ack = 1'b0;
    n_run++; if (busy !== 1'b1 || irq !== 1'b0) begin n_fail++; $display("FAIL single_ack: got busy %h irq %h want 1 0", busy, irq); end
    n_run++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL single_ack_pending: got %h want 0", pending); end
    ret = 1'b1; tick(); ret = 1'b0;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_ret: got %h want 0", busy); end
    tick();
    n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %h want 0", irq); end
  endtask

  task automatic test_priority();
    src = 4'b1010; tick(); src = 4'b1000;
    n_run++; if (pending !== 4'b1010) begin n_fail++; $display("FAIL prio_pending: got %h want a", pending); end
    tick();
    n_run++; if (irq !== 1'b1 || id !== 2'd1 || vec !== 32'h110) begin n_fail++; $display("FAIL prio_first: got irq %h id %h vec %h want 1 1 110", irq, id, vec); end
    ack = 1'b1; tick(); ack = 1'b0;
    ret = 1'b1; tick(); ret = 1'b0;
    n_run++; if (irq !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL prio_ret: got irq %h busy %h want 0 0", irq, busy); end
    tick();
    n_run++; if (irq !== 1'b1 || id !== 2'd3 || vec !== 32'h130) begin n_fail++; $display("FAIL prio_second: got irq %h id %h vec %h want 1 3 130", irq, id, vec); end
    src = 4'b0000;
    ack = 1'b1; tick(); ack = 1'b0;
    ret = 1'b1; tick(); ret = 1'b0;
    tick();
    n_run++; if (irq !== 1'b0 || pending !== 4'b0000) begin n_fail++; $display("FAIL prio_done: got irq %h pending %h want 0 0", irq, pending); end
  endtask

  task automatic test_vec_write();
    vec_we = 1'b1; vec_idx = 2'd0; vec_wdata = 32'hDEAD_0000;
    ien_we = 1'b1; ien_wdata = 4'b0001;
    tick(); vec_we = 1'b0; ien_we = 1'b0;
    src = 4'b0001; tick(); src = 4'b0000; tick();
    n_run++; if (irq !== 1'b1 || id !== 2'd0 || vec !== 32'hDEAD_0000) begin n_fail++; $display("FAIL vec_write: got irq %h id %h vec %h want 1 0 dead0000", irq, id, vec); end
    ack = 1'b1; tick(); ack = 1'b0;
    ret = 1'b1; tick(); ret = 1'b0;
    ien_we = 1'b1; ien_wdata = 4'b0000; tick(); ien_we = 1'b0;
    src = 4'b0100; tick(); src = 4'b0000;
    n_run++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL vec_masked_pending: got %h want 4", pending); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL vec_masked_irq: got %h want 0", irq); end
    end
  endtask

  task automatic test_reset_busy();
    ien_we = 1'b1; ien_wdata = 4'b1111; tick(); ien_we = 1'b0;
    src = 4'b0101; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    n_run++; if (busy !== 1'b1 || pending !== m_pending) begin n_fail++; $display("FAIL rstb_pre: got busy %h pending %h want 1 %h", busy, pending, m_pending); end
    reset = 1'b1; src = 4'b0000; ret = 1'b1; tick(); reset = 1'b0; ret = 1'b0;
    n_run++; if (irq !== 1'b0 || busy !== 1'b0 || id !== 2'd0 || vec !== 32'd0) begin n_fail++; $display("FAIL rstb_out: got irq %h busy %h id %h vec %h want 0 0 0 0", irq, busy, id, vec); end
    n_run++; if (pending !== 4'b0000 || ien !== 4'b0000) begin n_fail++; $display("FAIL rstb_regs: got pending %h ien %h want 0 0", pending, ien); end
    ien_we = 1'b1; ien_wdata = 4'b1111; tick(); ien_we = 1'b0;
    src = 4'b0001; tick(); src = 4'b0000; tick();
    n_run++; if (irq !== 1'b1 || id !== 2'd0 || vec !== 32'h100) begin n_fail++; $display("FAIL rstb_table: got irq %h id %h vec %h want 1 0 100", irq, id, vec); end
    ack = 1'b1; tick(); ack = 1'b0;
    ret = 1'b1; tick(); ret = 1'b0;
  endtask

  task automatic test_gie_drop();
    src = 4'b0010; tick(); tick();
    n_run++; if (irq !== 1'b1 || id !== 2'd1) begin n_fail++; $display("FAIL gie_req: got irq %h id %h want 1 1", irq, id); end
    gie = 1'b0; tick();
    n_run++; if (irq !== 1'b0 || pending !== 4'b0010) begin n_fail++; $display("FAIL gie_drop: got irq %h pending %h want 0 2", irq, pending); end
    gie = 1'b1; tick();
    n_run++; if (irq !== 1'b1 || id !== 2'd1 || vec !== 32'h110) begin n_fail++; $display("FAIL gie_restore: got irq %h id %h vec %h want 1 1 110", irq, id, vec); end
    ack = 1'b1; tick(); ack = 1'b0; src = 4'b0000;
    ret = 1'b1; tick(); ret = 1'b0; tick();
    n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL gie_done: got %h want 0", irq); end
  endtask

  task automatic test_no_nesting();
    src = 4'b1000; tick(); tick();
    n_run++; if (irq !== 1'b1 || id !== 2'd3) begin n_fail++; $display("FAIL nest_req: got irq %h id %h want 1 3", irq, id); end
    ack = 1'b1; tick(); ack = 1'b0;
    src = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_run++; if (irq !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL nest_blocked: got irq %h busy %h want 0 1", irq, busy); end
    end
    ack = 1'b1; tick(); ack = 1'b0;
    n_run++; if (busy !== 1'b1 || irq !== 1'b0 || pending[0] !== 1'b1) begin n_fail++; $display("FAIL nest_ack_ignored: got busy %h irq %h pend0 %h want 1 0 1", busy, irq, pending[0]); end
    src = 4'b0001;
    ret = 1'b1; tick(); ret = 1'b0;
    n_run++; if (irq !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL nest_ret: got irq %h busy %h want 0 0", irq, busy); end
    tick();
    n_run++; if (irq !== 1'b1 || id !== 2'd0 || vec !== 32'h100) begin n_fail++; $display("FAIL nest_next: got irq %h id %h vec %h want 1 0 100", irq, id, vec); end
    ack = 1'b1; tick(); ack = 1'b0; src = 4'b0000;
    ret = 1'b1; tick(); ret = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) src = 4'($urandom);
      gie       = ($urandom_range(0, 7) != 0);
      ien_we    = ($urandom_range(0, 9) == 0);
      ien_wdata = 4'($urandom);
      vec_we    = ($urandom_range(0, 9) == 0);
      vec_idx   = 2'($urandom);
      vec_wdata = $urandom;
      ack       = ($urandom_range(0, 3) == 0);
      ret       = ($urandom_range(0, 3) == 0);
      tick();
      n_run++; if (irq !== m_irq) begin n_fail++; $display("FAIL rand_irq c=%0d: got %h want %h", c, irq, m_irq); end
      n_run++; if (busy !== m_busy) begin n_fail++; $display("FAIL rand_busy c=%0d: got %h want %h", c, busy, m_busy); end
      n_run++; if (id !== m_id) begin n_fail++; $display("FAIL rand_id c=%0d: got %h want %h", c, id, m_id); end
      n_run++; if (vec !== m_vec) begin n_fail++; $display("FAIL rand_vec c=%0d: got %h want %h", c, vec, m_vec); end
      n_run++; if (pending !== m_pending) begin n_fail++; $display("FAIL rand_pending c=%0d: got %h want %h", c, pending, m_pending); end
      n_run++; if (ien !== m_ien) begin n_fail++; $display("FAIL rand_ien c=%0d: got %h want %h", c, ien, m_ien); end
    end
    reset = 1'b0; ack = 1'b0; ret = 1'b0; ien_we = 1'b0; vec_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_vec_tab[i] = 32'h100 + 32'(i) * 32'h10;
    test_reset();
    test_single();
    test_priority();
    test_vec_write();
    test_reset_busy();
    test_gie_drop();
    test_no_nesting();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
